lsu_byte_seq: RTL and testbench

Load/store byte sequencer between the MEM stage and the byte-wide RAM arbiter. It accepts one load or store request of 1, 2 or 4 bytes, issues the bytes in little-endian order on the arbiter's data port (`mem_read`/`mem_write`/`mem_addr`/`mem_w_data`), and honours `mem_done` back-pressure on every byte. For loads it assembles the returned bytes, sign- or zero-extends them to 32 bits, and returns them to MEM with a one-cycle response pulse.

---
 rtl/lsu_byte_seq.sv | 118 +++++++++++
 tb/tb_lsu_byte_seq.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_byte_seq.sv
// lsu_byte_seq: byte-serial load/store sequencer between MEM and the
// byte-wide RAM arbiter; little-endian, with sign/zero-extending loads.
module lsu_byte_seq (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_w_data,
  input  logic [7:0]  mem_r_data,
  input  logic        mem_done
);

  typedef enum logic [1:0] {
    IDLE, ACCESS, TAIL, RESP
  } state_t;

  state_t      state, state_nx;
  logic        wr_q, sgn_q, pend;
  logic [1:0]  last_q, icnt, rcnt, inxt;
  logic [31:0] wdata_q, res_q, res_fin;
  logic        acc, hit, fin, in_acc;

  function automatic logic [31:0] ext(
    input logic [31:0] v,
    input logic [1:0]  last,
    input logic        sgn
  );
    case (last)
      2'd0:    ext = {{24{sgn & v[7]}}, v[7:0]};
      2'd1:    ext = {{16{sgn & v[15]}}, v[15:0]};
      default: ext = v;
    endcase
  endfunction

  assign in_acc     = (state == ACCESS);
  assign req_ready  = (state == IDLE) & rdy_in & ~rst_in;
  assign resp_valid = (state == RESP);
  assign mem_read   = in_acc & ~wr_q & rdy_in;
  assign mem_write  = in_acc & wr_q & rdy_in;

  assign acc  = req_valid & req_ready;
  assign hit  = (mem_read | mem_write) & mem_done;
  assign fin  = hit & (icnt == last_q);
  assign inxt = icnt + 2'd1;

  // upper result bytes are still zero, so OR-ing in the last byte is safe
  assign res_fin = res_q | ({24'd0, mem_r_data} << {rcnt, 3'b000});

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (req_valid & rdy_in) state_nx = ACCESS;
      ACCESS:  if (fin) state_nx = wr_q ? RESP : TAIL;
      TAIL:    if (pend) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_q       <= 1'b0;
      sgn_q      <= 1'b0;
      last_q     <= 2'd0;
      wdata_q    <= 32'd0;
      icnt       <= 2'd0;
      rcnt       <= 2'd0;
      pend       <= 1'b0;
      res_q      <= 32'd0;
      resp_rdata <= 32'd0;
      mem_addr   <= 32'd0;
      mem_w_data <= 8'd0;
    end else begin
      pend <= mem_read & mem_done;
      if (acc) begin
        wr_q       <= req_write;
        sgn_q      <= req_signed;
        last_q     <= req_size[1] ? 2'd3 : {1'b0, req_size[0]};
        wdata_q    <= req_wdata;
        icnt       <= 2'd0;
        rcnt       <= 2'd0;
        res_q      <= 32'd0;
        resp_rdata <= 32'd0;
        mem_addr   <= req_addr;
        mem_w_data <= req_wdata[7:0];
      end
      // address and data hold on the final byte
      if (hit & ~fin) begin
        icnt       <= inxt;
        mem_addr   <= mem_addr + 32'd1;
        mem_w_data <= wdata_q[{inxt, 3'b000} +: 8];
      end
      if (pend) begin
        res_q[{rcnt, 3'b000} +: 8] <= mem_r_data;
        rcnt <= rcnt + 2'd1;
      end
      if ((state == TAIL) & pend)
        resp_rdata <= ext(res_fin, last_q, sgn_q);
    end
  end

endmodule

// File: tb/tb_lsu_byte_seq.sv
// tb_lsu_byte_seq: directed and randomized checks of lsu_byte_seq
// against a transaction-level model with its own byte memory.
module tb_lsu_byte_seq;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        req_ready, resp_valid, mem_read, mem_write;
  logic [31:0] resp_rdata, mem_addr;
  logic [7:0]  mem_w_data;
  logic [7:0]  mem_r_data = 8'd0;
  logic        mem_done = 1'b1;

  lsu_byte_seq dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .req_valid(req_valid), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_w_data(mem_w_data), .mem_r_data(mem_r_data),
    .mem_done(mem_done)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // RAM seen by the DUT, and the model's own copy
  logic [7:0] ram   [logic [31:0]];
  logic [7:0] m_ram [logic [31:0]];

  function automatic logic [7:0] seed_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] rd_ram(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : seed_byte(a);
  endfunction

  function automatic logic [7:0] m_get(input logic [31:0] a);
    return m_ram.exists(a) ? m_ram[a] : seed_byte(a);
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] base,
                                           input int n, input bit sgn);
    longint v = 0;
    for (int i = 0; i < n; i++)
      v += longint'(m_get(base + 32'(i))) << (8 * i);
    if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1)))
      v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  task automatic poke(input logic [31:0] a, input logic [7:0] v);
    ram[a] = v;
    m_ram[a] = v;
  endtask

  // transaction-level model: bytes issued so far, cycle since accept
  bit          m_busy = 0, m_wr = 0, m_sgn = 0;
  int          m_n = 1, m_k = 0, m_t = 0, m_tlast = 0;
  logic [31:0] m_base = 0, m_wdata = 0, m_exp = 0;
  logic [31:0] m_rdata = 0, m_addr = 0;
  logic [7:0]  m_wd = 0;

  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      m_busy = 0; m_rdata = 0; m_addr = 0; m_wd = 0;
    end else if (!m_busy) begin
      if (req_valid && rdy_in) begin
        m_busy = 1; m_wr = req_write; m_sgn = req_signed;
        m_n = (req_size == 0) ? 1 : (req_size == 1) ? 2 : 4;
        m_base = req_addr; m_wdata = req_wdata;
        m_k = 0; m_t = 1; m_tlast = 0;
        m_addr = req_addr; m_wd = req_wdata[7:0];
        m_exp = req_write ? 32'd0 : load_val(req_addr, m_n, req_signed);
      end
    end else if (m_tlast > 0 && m_t == m_tlast + (m_wr ? 1 : 2)) begin
      m_busy = 0;
      m_rdata = m_exp;
    end else begin
      if (m_k < m_n && rdy_in && mem_done) begin
        if (m_wr) m_ram[m_base + 32'(m_k)] = 8'(m_wdata >> (8 * m_k));
        m_k++;
        if (m_k == m_n) m_tlast = m_t;
        else begin
          m_addr = m_base + 32'(m_k);
          m_wd = 8'(m_wdata >> (8 * m_k));
        end
      end
      m_t++;
    end
  end

  // environment: RAM responder and stall generator
  bit          rand_mode = 0;
  logic [31:0] rdy_mask = 0, done_mask = 0;
  logic        rd_hit;
  logic [31:0] rd_addr;

  always @(posedge clk_in) begin
    rd_hit = mem_read && mem_done;
    rd_addr = mem_addr;
    if (mem_write && mem_done && !rst_in) ram[mem_addr] = mem_w_data;
    #2;
    mem_r_data = rd_hit ? rd_ram(rd_addr) : 8'($urandom);
    if (rand_mode) begin
      rdy_in = ($urandom % 10) != 0;
      mem_done = ($urandom % 10) < 7;
    end else begin
      rdy_in = !(m_busy && m_t < 32 && rdy_mask[m_t % 32]);
      mem_done = !(m_busy && m_t < 32 && done_mask[m_t % 32]);
    end
  end

  int          obs_n = 0, obs_lat = 0, cnt_b2 = 0;
  logic [31:0] obs_rd = 0;

  always @(negedge clk_in) begin : cmp
    logic er, ew, ev;
    er = !rst_in && m_busy && m_k < m_n && rdy_in && !m_wr;
    ew = !rst_in && m_busy && m_k < m_n && rdy_in && m_wr;
    ev = !rst_in && m_busy && m_tlast > 0 &&
         m_t == m_tlast + (m_wr ? 1 : 2);
    chk("req_ready", 32'(req_ready), 32'(!rst_in && !m_busy && rdy_in));
    chk("mem_read", 32'(mem_read), 32'(er));
    chk("mem_write", 32'(mem_write), 32'(ew));
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_w_data", 32'(mem_w_data), 32'(m_wd));
    chk("resp_valid", 32'(resp_valid), 32'(ev));
    if (ev) chk("resp_rdata", resp_rdata, m_exp);
    else if (!m_busy) chk("rdata_hold", resp_rdata, m_rdata);
    if (resp_valid) begin
      obs_n++;
      obs_rd = resp_rdata;
      obs_lat = m_t;
    end
    if (mem_write && mem_addr == 32'h0003_0002) cnt_b2++;
  end

  task automatic start_req(input bit w, input logic [1:0] sz,
                           input bit s, input logic [31:0] a,
                           input logic [31:0] d);
    req_valid = 1; req_write = w; req_size = sz;
    req_signed = s; req_addr = a; req_wdata = d;
    for (int i = 0; i < 100 && !m_busy; i++) begin
      @(posedge clk_in); #1;
    end
    total++;
    if (!m_busy) begin
      bad++;
      $display("FAIL accept: got no acceptance want accepted");
    end
    req_valid = 0; req_write = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
  endtask

  task automatic wait_resp();
    int n0 = obs_n;
    for (int i = 0; i < 300 && obs_n == n0; i++) begin
      @(posedge clk_in); #1;
    end
    total++;
    if (obs_n == n0) begin
      bad++;
      $display("FAIL resp: got no resp_valid want pulse");
    end
  endtask

  task automatic do_req(input bit w, input logic [1:0] sz,
                        input bit s, input logic [31:0] a,
                        input logic [31:0] d);
    start_req(w, sz, s, a, d);
    wait_resp();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_in = 1;
    @(posedge clk_in); @(posedge clk_in); #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    rst_in = 0;
    @(posedge clk_in); #1;
    chk("idle_ready", 32'(req_ready), 32'd1);

    poke(32'h100, 8'h11); poke(32'h101, 8'h22);
    poke(32'h102, 8'h33); poke(32'h103, 8'h44);
    do_req(0, 2'd2, 0, 32'h100, 0);
    chk("lw_data", obs_rd, 32'h4433_2211);
    chk("lw_lat", 32'(obs_lat), 32'd6);

    poke(32'h20, 8'h80);
    do_req(0, 2'd0, 1, 32'h20, 0);
    chk("lb_s", obs_rd, 32'hFFFF_FF80);
    chk("lb_lat", 32'(obs_lat), 32'd3);
    do_req(0, 2'd0, 0, 32'h20, 0);
    chk("lbu", obs_rd, 32'h0000_0080);

    poke(32'h40, 8'h34); poke(32'h41, 8'hF2);
    do_req(0, 2'd1, 1, 32'h40, 0);
    chk("lh_s", obs_rd, 32'hFFFF_F234);

    done_mask = 32'b111000;
    cnt_b2 = 0;
    do_req(1, 2'd3, 0, 32'h0003_0000, 32'hDEAD_BEEF);
    done_mask = 0;
    chk("sw_lat", 32'(obs_lat), 32'd8);
    chk("sw_rdata", obs_rd, 32'd0);
    chk("sw_b2_hold", 32'(cnt_b2), 32'd4);
    chk("sw_b0", 32'(rd_ram(32'h0003_0000)), 32'hEF);
    chk("sw_b1", 32'(rd_ram(32'h0003_0001)), 32'hBE);
    chk("sw_b2", 32'(rd_ram(32'h0003_0002)), 32'hAD);
    chk("sw_b3", 32'(rd_ram(32'h0003_0003)), 32'hDE);

    do_req(1, 2'd1, 0, 32'hFFFF_FFFF, 32'h0000_A1B2);
    chk("sh_wrap0", 32'(rd_ram(32'hFFFF_FFFF)), 32'hB2);
    chk("sh_wrap1", 32'(rd_ram(32'h0000_0000)), 32'hA1);

    poke(32'h200, 8'h01); poke(32'h201, 8'h82);
    poke(32'h202, 8'h03); poke(32'h203, 8'hF4);
    rdy_mask = 32'b1100;
    do_req(0, 2'd2, 0, 32'h200, 0);
    rdy_mask = 0;
    chk("lw_rdy_data", obs_rd, 32'hF403_8201);
    chk("lw_rdy_lat", 32'(obs_lat), 32'd8);

    start_req(1, 2'd2, 0, 32'h4000, 32'hCAFE_BABE);
    for (int i = 0; i < 50 && m_k < 2; i++) begin
      @(posedge clk_in); #1;
    end
    #2 rst_in = 1;
    #1;
    chk("arst_write", 32'(mem_write), 32'd0);
    chk("arst_addr", mem_addr, 32'd0);
    chk("arst_wdata", 32'(mem_w_data), 32'd0);
    chk("arst_ready", 32'(req_ready), 32'd0);
    chk("arst_rdata", resp_rdata, 32'd0);
    @(posedge clk_in); @(posedge clk_in); #1;
    rst_in = 0;
    chk("arst_b1", 32'(rd_ram(32'h4001)), 32'hBA);
    chk("arst_b2", 32'(rd_ram(32'h4002)), 32'(seed_byte(32'h4002)));
    chk("arst_b3", 32'(rd_ram(32'h4003)), 32'(seed_byte(32'h4003)));
    poke(32'h60, 8'h7F);
    do_req(0, 2'd0, 1, 32'h60, 0);
    chk("lb_after_rst", obs_rd, 32'h0000_007F);

    rand_mode = 1;
    for (int t = 0; t < 150; t++) begin
      logic [31:0] a;
      a = ($urandom % 4 == 0) ? 32'hFFFF_FFFC + ($urandom % 4)
                              : ($urandom & 32'h3F);
      repeat ($urandom % 3) begin @(posedge clk_in); #1; end
      do_req(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
    end
    rand_mode = 0;
    repeat (3) @(posedge clk_in);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
